ringbuf_pairfold: RTL and testbench

- Parametrised successor to the in-order ring buffer used by P during sumcheck.
- Holds a variable-length logical sequence in a circular register array. Supports two in-order traversal modes:
  - rotate: read one element, write one back.
  - fold: read an adjacent pair, write one back, so the sequence halves each round, as needed when binding a variable per sumcheck round.
- Tracks round boundaries and the live length, and flags misuse.

---
 rtl/ringbuf_pairfold.sv | 131 +++++++++++++
 tb/tb_ringbuf_pairfold.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ringbuf_pairfold.sv
// Circular register-array sequence buffer with in-order rotate and pair-fold traversal.
// Optional debug port q_all (logical-order snapshot) is enabled by defining RINGBUF_Q_ALL_EN.
module ringbuf_pairfold #(
  parameter int nbits  = 8,
  parameter int nwords = 8
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         clr,
  input  logic                         ld,
  input  logic                         en,
  input  logic                         fold,
  input  logic                         wren,
  input  logic [nbits-1:0]             d,
  output logic [nbits-1:0]             q0,
  output logic [nbits-1:0]             q1,
  output logic                         q1_vld,
  output logic [$clog2(nwords+1)-1:0]  count,
  output logic [$clog2(nwords+1)-1:0]  rem,
  output logic                         round_done,
`ifdef RINGBUF_Q_ALL_EN
  output logic [nwords-1:0][nbits-1:0] q_all,
`endif
  output logic                         err
);

  localparam int CW = $clog2(nwords + 1);
  localparam int PW = $clog2(nwords);
  localparam logic [CW-1:0] FULL = CW'(nwords);

  generate
    if (nwords < 2) begin : g_bad_nwords
      $error("ringbuf_pairfold: nwords must be >= 2");
    end
    if (nbits < 1) begin : g_bad_nbits
      $error("ringbuf_pairfold: nbits must be >= 1");
    end
  endgenerate

  logic [nbits-1:0] mem [nwords];
  logic [PW-1:0]    h, t;

  logic [PW-1:0]    h1, h2, h_step;
  logic             pair;
  logic             step_ok;
  logic [CW-1:0]    count_step;
  logic [CW-1:0]    rem_dec;
  logic             mem_we;
  logic [nbits-1:0] mem_wd;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(nwords - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    h1         = wrap_inc(h);
    h2         = wrap_inc(h1);
    q0         = (count == '0) ? '0 : mem[h];
    q1_vld     = (rem >= CW'(2));
    q1         = q1_vld ? mem[h1] : '0;
    step_ok    = en && (count != '0);
    // A fold consumes two elements only while the partner is still in this round.
    pair       = fold && q1_vld;
    h_step     = pair ? h2 : h1;
    count_step = pair ? count - CW'(1) : count;
    rem_dec    = pair ? rem - CW'(2) : rem - CW'(1);
    mem_we     = rstb && !clr && (step_ok || (!en && ld && (count != FULL)));
    mem_wd     = en ? (wren ? d : q0) : d;
  end

  // Storage: the write slot is the tail; when full, t==h and the popped slot is reused.
  always_ff @(posedge clk) begin
    if (mem_we) mem[t] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      h          <= '0;
      t          <= '0;
      count      <= '0;
      rem        <= '0;
      err        <= 1'b0;
      round_done <= 1'b0;
    end else begin
      round_done <= 1'b0;
      if (clr) begin
        count <= '0;
        rem   <= '0;
        h     <= t;
      end else if (en) begin
        if (count == '0) begin
          err <= 1'b1;
        end else begin
          h     <= h_step;
          t     <= wrap_inc(t);
          count <= count_step;
          if (rem_dec == '0) begin
            rem        <= count_step;
            round_done <= 1'b1;
          end else begin
            rem <= rem_dec;
          end
        end
      end else if (ld) begin
        if (count == FULL) begin
          err <= 1'b1;
        end else begin
          t     <= wrap_inc(t);
          count <= count + CW'(1);
          rem   <= count + CW'(1);
        end
      end
    end
  end

`ifdef RINGBUF_Q_ALL_EN
  function automatic logic [PW-1:0] logical_idx(input logic [PW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= nwords) s = s - nwords;
    return PW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < nwords; i++) begin
      q_all[i] = (i < int'(count)) ? mem[logical_idx(h, i)] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_ringbuf_pairfold.sv
// Scoreboard bench for ringbuf_pairfold: a queue-based sequence model predicts each cycle's outputs.
module tb_ringbuf_pairfold;

  logic       clk = 1'b0;
  logic       rstb, clr, ld, en, fold, wren;
  logic [7:0] d;
  logic [7:0] q0, q1;
  logic       q1_vld, round_done, err;
  logic [3:0] count, rem;
`ifdef RINGBUF_Q_ALL_EN
  logic [7:0][7:0] q_all;
`endif

  ringbuf_pairfold #(.nbits(8), .nwords(8)) dut (
    .clk(clk), .rstb(rstb), .clr(clr), .ld(ld), .en(en), .fold(fold), .wren(wren),
    .d(d), .q0(q0), .q1(q1), .q1_vld(q1_vld), .count(count), .rem(rem),
    .round_done(round_done),
`ifdef RINGBUF_Q_ALL_EN
    .q_all(q_all),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: the logical sequence as a queue.
  logic [7:0] mq[$];
  int         mrem = 0;
  bit         merr = 0;
  bit         mrd  = 0;

  typedef struct {
    logic [7:0] q0;
    logic [7:0] q1;
    logic       vld;
    int         cnt;
    int         rem;
    logic       err;
    logic       rd;
    logic [7:0] all [8];
  } exp_t;
  exp_t sb[$];

  function automatic logic [7:0] m_q0();
    return (mq.size() == 0) ? 8'd0 : mq[0];
  endfunction

  function automatic logic [7:0] m_q1();
    return (mrem >= 2) ? mq[1] : 8'd0;
  endfunction

  task automatic model_step(input bit rb, c, l, e, f, w, input logic [7:0] dv);
    logic [7:0] wv;
    int k;
    mrd = 0;
    if (!rb) begin
      mq.delete(); mrem = 0; merr = 0;
    end else if (c) begin
      mq.delete(); mrem = 0;
    end else if (e) begin
      if (mq.size() == 0) merr = 1;
      else begin
        k  = (f && mrem >= 2) ? 2 : 1;
        wv = w ? dv : mq[0];
        for (int i = 0; i < k; i++) void'(mq.pop_front());
        mq.push_back(wv);
        mrem -= k;
        if (mrem == 0) begin mrem = mq.size(); mrd = 1; end
      end
    end else if (l) begin
      if (mq.size() < 8) begin mq.push_back(dv); mrem = mq.size(); end
      else merr = 1;
    end
  endtask

  task automatic cyc(input bit rb, c, l, e, f, w, input logic [7:0] dv);
    exp_t x, o;
    rstb = rb; clr = c; ld = l; en = e; fold = f; wren = w; d = dv;
    model_step(rb, c, l, e, f, w, dv);
    x.q0 = m_q0(); x.q1 = m_q1(); x.vld = (mrem >= 2);
    x.cnt = mq.size(); x.rem = mrem; x.err = merr; x.rd = mrd;
    for (int i = 0; i < 8; i++) x.all[i] = (i < mq.size()) ? mq[i] : 8'd0;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    o = sb.pop_front();
    chk("q0", 32'(q0), 32'(o.q0));
    chk("q1", 32'(q1), 32'(o.q1));
    chk("q1_vld", 32'(q1_vld), 32'(o.vld));
    chk("count", 32'(count), 32'(o.cnt));
    chk("rem", 32'(rem), 32'(o.rem));
    chk("err", 32'(err), 32'(o.err));
    chk("round_done", 32'(round_done), 32'(o.rd));
`ifdef RINGBUF_Q_ALL_EN
    for (int i = 0; i < 8; i++) chk("q_all", 32'(q_all[i]), 32'(o.all[i]));
`endif
    rstb = 1'b1; clr = 1'b0; ld = 1'b0; en = 1'b0; fold = 1'b0; wren = 1'b0;
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 8'd0);
    cyc(0, 0, 0, 0, 0, 0, 8'd0);
  endtask

  int rd_cnt;

  initial begin
    rstb = 1'b0; clr = 1'b0; ld = 1'b0; en = 1'b0; fold = 1'b0; wren = 1'b0; d = '0;
    @(negedge clk);
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_err", 32'(err), 0);

    // Fill 1..5
    for (int i = 1; i <= 5; i++) cyc(1, 0, 1, 0, 0, 0, 8'(i));
    chk("fill_count", 32'(count), 5);
    chk("fill_rem", 32'(rem), 5);
    chk("fill_q0", 32'(q0), 1);
    chk("fill_q1", 32'(q1), 2);
    chk("fill_vld", 32'(q1_vld), 1);

    // One rotate round with modification
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 1, 0, 1, 8'(10 + m_q0()));
      rd_cnt += int'(round_done);
    end
    chk("rot_rd_pulses", 32'(rd_cnt), 1);
    chk("rot_count", 32'(count), 5);
    for (int i = 0; i < 5; i++) begin
      chk("rot_q0_seq", 32'(q0), 32'(11 + i));
      cyc(1, 0, 0, 1, 0, 0, 8'd0);
    end

    // Fold rounds on 1..5
    cyc(1, 1, 0, 0, 0, 0, 8'd0);
    for (int i = 1; i <= 5; i++) cyc(1, 0, 1, 0, 0, 0, 8'(i));
    for (int i = 0; i < 3; i++) begin
      chk("fold_vld", 32'(q1_vld), (i < 2) ? 1 : 0);
      cyc(1, 0, 0, 1, 1, 1, 8'(m_q0() + m_q1()));
    end
    chk("fold_count", 32'(count), 3);
    chk("fold_rem", 32'(rem), 3);
    chk("fold_rd", 32'(round_done), 1);
    chk("fold_q0", 32'(q0), 3);
    chk("fold_q1", 32'(q1), 7);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 1, 1, 1, 8'(m_q0() + m_q1()));
    chk("fold_r2_count", 32'(count), 2);
    cyc(1, 0, 0, 1, 1, 1, 8'(m_q0() + m_q1()));
    chk("fold_r3_count", 32'(count), 1);
    chk("fold_r3_q0", 32'(q0), 15);
    cyc(1, 0, 0, 1, 1, 0, 8'd0);
    chk("fold_l1_count", 32'(count), 1);
    chk("fold_l1_rd", 32'(round_done), 1);

    // Full buffer, overflow, wrap
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, 0, 0, 8'(20 + i));
    cyc(1, 0, 1, 0, 0, 0, 8'd99);
    chk("ovf_err", 32'(err), 1);
    chk("ovf_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 1, 0, 0, 8'd0);
      chk("wrap_q0", 32'(q0), 32'(20 + ((i + 1) % 8)));
    end
    cyc(1, 0, 1, 1, 0, 0, 8'd77);
    chk("ld_en_count", 32'(count), 8);

    // Empty step error, reset mid-round
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 0, 8'(i + 1));
    cyc(1, 1, 0, 0, 0, 0, 8'd0);
    chk("clr_err", 32'(err), 0);
    cyc(1, 0, 0, 1, 0, 0, 8'd0);
    chk("empty_en_err", 32'(err), 1);
    chk("empty_q0", 32'(q0), 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 0, 8'(i + 1));
    cyc(1, 0, 0, 1, 0, 0, 8'd0);
    cyc(1, 0, 0, 1, 0, 0, 8'd0);
    cyc(0, 0, 0, 1, 0, 0, 8'd0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_rem", 32'(rem), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_rd", 32'(round_done), 0);

`ifdef RINGBUF_Q_ALL_EN
    for (int i = 1; i <= 3; i++) cyc(1, 0, 1, 0, 0, 0, 8'(i));
    cyc(1, 0, 0, 1, 0, 0, 8'd0);
    chk("q_all0", 32'(q_all[0]), 2);
    chk("q_all1", 32'(q_all[1]), 3);
    chk("q_all2", 32'(q_all[2]), 1);
    chk("q_all3", 32'(q_all[3]), 0);
`endif

    // Random mixed traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(1, ($urandom % 20) == 0, ($urandom % 2) == 0, ($urandom % 3) == 0,
          $urandom % 2, $urandom % 2, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
